// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy playfield blocks.
// The playfield is COLS columns of ROWS bits each; column 0 is the leftmost.
package flappy_pkg;

  localparam int ROWS = 16;
  localparam int COLS = 16;

  typedef logic [ROWS-1:0] column_t;

  localparam column_t EMPTY_COL = 16'h0000;

  typedef enum logic [2:0] {
    WAIT,
    REQ,
    LOAD,
    SHIFT,
    HALT
  } scroller_state_t;

  // Score counter that sticks at its maximum instead of wrapping.
  function automatic logic [7:0] satInc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/scroll_divider.sv
// Scroll-rate divider: counts enabled cycles and pulses tick on the last one.
// tick is combinational so the FSM can leave WAIT on the same edge the count wraps.
module scroll_divider #(
  parameter int SCROLL_DIV = 12500000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clr,
  output logic tick
);

  localparam int CW = (SCROLL_DIV > 2) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCROLL_DIV - 1);

  logic [CW-1:0] r_count;

  assign tick = enable && (r_count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clr || tick) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/pipe_scroller.sv
// Scrolling 16x16 playfield: requests pipe columns, shifts them left,
// serves rows to the LED driver and tracks collision and score.
module pipe_scroller
  import flappy_pkg::*;
#(
  parameter int SCROLL_DIV   = 12500000,
  parameter int PIPE_SPACING = 4,
  parameter int BIRD_COL     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        activateMake,
  input  logic [15:0] newPipe,
  input  logic [3:0]  rowSel,
  output logic [15:0] rowData,
  input  logic [3:0]  birdRow,
  output logic        collision,
  output logic [7:0]  score
);

  localparam int SPACE_W = (PIPE_SPACING > 2) ? $clog2(PIPE_SPACING) : 1;
  localparam logic [SPACE_W-1:0] SPACE_LAST = SPACE_W'(PIPE_SPACING - 1);

  scroller_state_t     r_state;
  scroller_state_t     w_nextState;
  column_t             r_col [COLS];
  logic [SPACE_W-1:0]  r_spaceCnt;
  logic                r_collision;
  logic [7:0]          r_score;

  logic                w_inWait;
  logic                w_tick;
  logic                w_hit;
  logic                w_doShift;
  logic                w_birdColBusy;
  column_t             w_insert;
  column_t             w_birdCol;

  assign w_inWait      = (r_state == WAIT);
  assign w_birdCol     = r_col[BIRD_COL];
  assign w_birdColBusy = (w_birdCol != EMPTY_COL);
  // HALT never re-evaluates the hit; everything is frozen there anyway.
  assign w_hit         = (r_state != HALT) && w_birdCol[birdRow];
  assign w_doShift     = ((r_state == LOAD) || (r_state == SHIFT)) && !w_hit;
  assign w_insert      = (r_state == LOAD) ? column_t'(newPipe) : EMPTY_COL;

  scroll_divider #(
    .SCROLL_DIV(SCROLL_DIV)
  ) u_divider (
    .clk    (clk),
    .reset  (reset),
    .enable (enable && w_inWait),
    .clr    (!w_inWait),
    .tick   (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= WAIT;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      WAIT:  if (w_tick) w_nextState = (r_spaceCnt == '0) ? REQ : SHIFT;
      REQ:   w_nextState = LOAD;
      LOAD:  w_nextState = WAIT;
      SHIFT: w_nextState = WAIT;
      HALT:  w_nextState = HALT;
      default: w_nextState = WAIT;
    endcase
    if (w_hit) begin
      w_nextState = HALT;
    end
  end

  // Driven straight from the state so a reset pulse drops it immediately.
  assign activateMake = (r_state == REQ);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < COLS; i++) begin
        r_col[i] <= EMPTY_COL;
      end
    end else if (w_doShift) begin
      for (int i = 0; i < COLS - 1; i++) begin
        r_col[i] <= r_col[i+1];
      end
      r_col[COLS-1] <= w_insert;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_spaceCnt <= '0;
    end else if (w_doShift) begin
      r_spaceCnt <= (r_spaceCnt == SPACE_LAST) ? '0 : r_spaceCnt + SPACE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_collision <= 1'b0;
      r_score     <= 8'h00;
    end else begin
      if (w_hit) begin
        r_collision <= 1'b1;
      end
      // A pipe scrolling out of the bird column counts as passed.
      if (w_doShift && w_birdColBusy) begin
        r_score <= satInc8(r_score);
      end
    end
  end

  assign collision = r_collision;
  assign score     = r_score;

  always_comb begin
    rowData = '0;
    for (int c = 0; c < COLS; c++) begin
      rowData[c] = r_col[c][rowSel];
    end
  end

endmodule

// File: tb/tb_pipe_scroller.sv
// Self-checking bench for pipe_scroller: directed scenarios plus randomized
// play compared every cycle against a queue-based playfield model.
module tb_pipe_scroller;

  localparam int SD = 4;
  localparam int PS = 4;
  localparam int BC = 3;

  localparam int M_WAITING    = 0;
  localparam int M_REQUESTING = 1;
  localparam int M_LOADING    = 2;
  localparam int M_SHIFTING   = 3;

  typedef struct {
    logic [3:0]  rowSel;
    logic [15:0] expRow;
  } rowVec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        activateMake;
  logic [15:0] newPipe;
  logic [3:0]  rowSel;
  logic [15:0] rowData;
  logic [3:0]  birdRow;
  logic        collision;
  logic [7:0]  score;

  int testsRun = 0;
  int testsFailed = 0;

  // Model state: the playfield as a queue, leftmost column at the front.
  logic [15:0] mField[$];
  int mDiv, mStage, mSteps, mScore;
  bit mHit;

  // Stimulus knobs
  bit          enableIn;
  logic [3:0]  birdIn;
  int          rowSelForce = -1;
  logic [15:0] pipeMask, pipeOr;
  bit          lastMake;
  int          cycleNum = 0;
  int          lastMakeCycle = -1;
  int          lastInterval = -1;
  int          makeCount = 0;

  rowVec_t rowTable[8];

  pipe_scroller #(
    .SCROLL_DIV  (SD),
    .PIPE_SPACING(PS),
    .BIRD_COL    (BC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .activateMake(activateMake),
    .newPipe     (newPipe),
    .rowSel      (rowSel),
    .rowData     (rowData),
    .birdRow     (birdRow),
    .collision   (collision),
    .score       (score)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input logic [31:0] actual,
                          input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic void modelReset();
    mField.delete();
    for (int i = 0; i < 16; i++) mField.push_back(16'h0000);
    mDiv = 0;
    mStage = M_WAITING;
    mSteps = 0;
    mScore = 0;
    mHit = 1'b0;
  endfunction

  // One clock edge of the game rules: a step every SD enabled waiting cycles,
  // every PS-th step fetches a pipe, and the bird cell is checked each cycle.
  function automatic void modelStep(input bit en, input logic [3:0] bird,
                                    input logic [15:0] pipeIn);
    logic [15:0] birdColumn;
    if (mHit) return;
    birdColumn = mField[BC];
    if (birdColumn[bird]) begin
      mHit = 1'b1;
      return;
    end
    case (mStage)
      M_WAITING: begin
        if (en) begin
          mDiv++;
          if (mDiv == SD) begin
            mDiv = 0;
            mStage = (mSteps % PS == 0) ? M_REQUESTING : M_SHIFTING;
          end
        end
      end
      M_REQUESTING: mStage = M_LOADING;
      default: begin
        if (birdColumn != 16'h0000 && mScore < 255) mScore++;
        void'(mField.pop_front());
        mField.push_back((mStage == M_LOADING) ? pipeIn : 16'h0000);
        mSteps++;
        mStage = M_WAITING;
      end
    endcase
  endfunction

  task automatic sampleCycle();
    @(negedge clk);
    cycleNum++;
    rowSel = (rowSelForce >= 0) ? 4'(rowSelForce) : 4'($urandom_range(0, 15));
    #1;
  endtask

  task automatic checkOutput();
    logic [15:0] expRow;
    logic [15:0] colTmp;
    for (int c = 0; c < 16; c++) begin
      colTmp = mField[c];
      expRow[c] = colTmp[rowSel];
    end
    checkVal("activateMake", 32'(activateMake), 32'(mStage == M_REQUESTING && !mHit));
    checkVal("collision", 32'(collision), 32'(mHit));
    checkVal("score", 32'(score), 32'(mScore));
    checkVal("rowData", 32'(rowData), 32'(expRow));
    if (activateMake === 1'b1) begin
      makeCount++;
      if (lastMakeCycle >= 0) lastInterval = cycleNum - lastMakeCycle;
      lastMakeCycle = cycleNum;
    end
  endtask

  // The generator answers a request with a pipe in the following cycle.
  task automatic applyStimulus();
    enable  = enableIn;
    birdRow = birdIn;
    newPipe = lastMake ? ((16'($urandom) & pipeMask) | pipeOr) : 16'($urandom);
    lastMake = (activateMake === 1'b1);
    modelStep(enable, birdRow, newPipe);
  endtask

  task automatic runCycle();
    sampleCycle();
    checkOutput();
    applyStimulus();
  endtask

  task automatic doReset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    enable = 1'b0;
    enableIn = 1'b0;
    modelReset();
    lastMake = 1'b0;
    lastMakeCycle = -1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic runUntilSteps(input int target);
    for (int k = 0; k < 3000 && mSteps < target; k++) runCycle();
    if (mSteps < target) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL step budget: got %0d steps, expected %0d", mSteps, target);
    end
  endtask

  // Raise enable and count cycles until the request pulse appears.
  task automatic measureRequest(output int n);
    bit seen;
    seen = 1'b0;
    enableIn = 1'b1;
    runCycle();
    n = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      sampleCycle();
      checkOutput();
      n++;
      seen = (activateMake === 1'b1);
      applyStimulus();
    end
    checkVal("request seen", 32'(seen), 32'd1);
  endtask

  initial begin
    int n;
    int mk;
    bit found;

    rowTable[0] = '{4'd15, 16'h8000};
    rowTable[1] = '{4'd14, 16'h8000};
    rowTable[2] = '{4'd13, 16'h0000};
    rowTable[3] = '{4'd12, 16'h0000};
    rowTable[4] = '{4'd11, 16'h0000};
    rowTable[5] = '{4'd10, 16'h0000};
    rowTable[6] = '{4'd9,  16'h8000};
    rowTable[7] = '{4'd0,  16'h8000};

    reset = 1'b0;
    enable = 1'b0;
    birdRow = 4'd11;
    rowSel = 4'd0;
    newPipe = 16'h0000;
    birdIn = 4'd11;
    pipeMask = 16'h0000;
    pipeOr = 16'hC3FF;
    modelReset();

    // Reset state with the game idle
    doReset();
    repeat (20) runCycle();
    checkVal("reset makeCount", 32'(makeCount), 32'd0);
    checkVal("reset score", 32'(score), 32'd0);
    checkVal("reset collision", 32'(collision), 32'd0);
    for (int r = 0; r < 16; r++) begin
      rowSelForce = r;
      sampleCycle();
      checkVal($sformatf("reset row%0d", r), 32'(rowData), 32'd0);
      checkOutput();
      applyStimulus();
    end
    rowSelForce = -1;

    // First request, then enable dropped while REQ/LOAD complete
    measureRequest(n);
    checkVal("first request latency", 32'(n), 32'(SD));
    enableIn = 1'b0;
    runCycle();
    for (int i = 0; i < 8; i++) begin
      rowSelForce = rowTable[i].rowSel;
      sampleCycle();
      checkVal($sformatf("loaded row%0d", rowTable[i].rowSel), 32'(rowData),
               32'(rowTable[i].expRow));
      checkOutput();
      applyStimulus();
    end
    rowSelForce = -1;

    // Bird in the gap while the first pipe passes
    enableIn = 1'b1;
    birdIn = 4'd11;
    runUntilSteps(13);
    sampleCycle();
    checkVal("score before pass", 32'(score), 32'd0);
    checkOutput();
    applyStimulus();
    runUntilSteps(14);
    sampleCycle();
    checkVal("score after pass", 32'(score), 32'd1);
    checkVal("no collision in gap", 32'(collision), 32'd0);
    checkOutput();
    applyStimulus();
    checkVal("request interval", 32'(lastInterval), 32'((PS - 1) * (SD + 1) + SD + 2));

    // Bird moves into a pipe wall as it reaches the bird column
    runUntilSteps(25);
    sampleCycle();
    checkOutput();
    birdIn = 4'd0;
    applyStimulus();
    sampleCycle();
    checkVal("hit collision", 32'(collision), 32'd1);
    checkVal("score at hit", 32'(score), 32'd3);
    checkOutput();
    applyStimulus();
    mk = makeCount;
    for (int i = 0; i < 50; i++) begin
      birdIn = 4'($urandom_range(0, 15));
      runCycle();
    end
    checkVal("halt requests", 32'(makeCount - mk), 32'd0);
    checkVal("halt score", 32'(score), 32'd3);
    checkVal("halt collision", 32'(collision), 32'd1);

    // Asynchronous reset in the middle of a request
    doReset();
    birdIn = 4'd11;
    repeat (3) runCycle();
    measureRequest(n);
    checkVal("baseline latency", 32'(n), 32'(SD));
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      sampleCycle();
      checkOutput();
      if (activateMake === 1'b1 && mSteps == PS) found = 1'b1;
      else applyStimulus();
    end
    checkVal("second request found", 32'(found), 32'd1);
    rowSel = 4'd0;
    #1;
    reset = 1'b0;
    #1;
    checkVal("async reset activateMake", 32'(activateMake), 32'd0);
    checkVal("async reset rowData", 32'(rowData), 32'd0);
    checkVal("async reset score", 32'(score), 32'd0);
    modelReset();
    enable = 1'b0;
    enableIn = 1'b0;
    lastMake = 1'b0;
    lastMakeCycle = -1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    measureRequest(n);
    checkVal("restart latency", 32'(n), 32'(SD));
    repeat (10) runCycle();

    // Randomized play against the model
    pipeMask = 16'hFFFF;
    pipeOr = 16'h0000;
    for (int ep = 0; ep < 4; ep++) begin
      doReset();
      for (int i = 0; i < 400; i++) begin
        enableIn = ($urandom_range(0, 9) != 0);
        birdIn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(10, 13));
        runCycle();
      end
    end

    // Long run through the gaps until the score saturates
    doReset();
    pipeMask = 16'hC3FF;
    pipeOr = 16'h0001;
    enableIn = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      birdIn = 4'($urandom_range(10, 13));
      runCycle();
    end
    checkVal("score saturated", 32'(score), 32'hFF);
    checkVal("saturation collision", 32'(collision), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
